// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared types for the pipeline-stage register family.
//   stage_state_e : occupancy state of a stage (EMPTY / ONE / TWO entries)
//   state_to_occ  : maps a state onto the 2-bit occupancy count
// ---------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } stage_state_e;

  // Number of entries held in a given state. The encoding already equals the
  // count, but the explicit table keeps the occupancy port independent of
  // any future re-encoding of the state.
  function automatic logic [1:0] state_to_occ(input stage_state_e st);
    logic [1:0] occ;
    case (st)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_TWO:   occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/flopenr.sv
// ---------------------------------------------------------------------------
// flopenr
// Resettable flop with load enable and synchronous clear. Both reset and
// clear load RESET_VAL; reset has priority over clear, clear over enable.
//   clk    in  1      clock, posedge
//   reset  in  1      synchronous, active-high
//   i_clr  in  1      synchronous clear to RESET_VAL
//   i_en   in  1      load i_d
//   i_d    in  WIDTH  data in
//   o_q    out WIDTH  registered data out
// ---------------------------------------------------------------------------
module flopenr #(
  parameter int              WIDTH     = 9,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Data register: reset > clear > load > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= RESET_VAL;
    end else if (i_clr) begin
      r_q <= RESET_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Pipeline-stage register with valid/ready handshake, flush and an optional
// skid entry. With SKID=1 the stage holds up to two beats and in_ready is a
// flop output, so no combinational ready path crosses the stage boundary.
// With SKID=0 it is a single entry whose in_ready follows out_ready.
//   clk        in   1      clock, posedge
//   reset      in   1      synchronous, active-high
//   flush      in   1      synchronous squash of all held entries
//   in_valid   in   1      upstream payload valid
//   in_ready   out  1      stage can accept this cycle
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      downstream payload valid
//   out_ready  in   1      downstream accepts
//   out_data   out  WIDTH  payload presented downstream (main register)
//   occupancy  out  2      entries held: 0, 1 or 2
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 9,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SKID      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  stage_state_e     r_state;
  stage_state_e     w_next_state;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_en;
  logic             w_main_sel_skid;
  logic             w_skid_en;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  // Any non-empty state has the head beat sitting in the main register.
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_fire   = in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;

  // Next-state and register-enable decode; flush overrides the handshake.
  always_comb begin
    w_next_state    = r_state;
    w_main_en       = 1'b0;
    w_main_sel_skid = 1'b0;
    w_skid_en       = 1'b0;
    if (flush) begin
      // Held entries and any beat accepted this cycle are squashed.
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_next_state = ST_ONE;
            w_main_en    = 1'b1;
          end else begin
            w_next_state = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_next_state = ST_ONE;
            w_main_en    = 1'b1;
          end else if (w_in_fire) begin
            // Head is stalled: park the new beat behind it. Without a skid
            // entry in_ready tracks out_ready, so this arm cannot be reached.
            if (SKID != 0) begin
              w_next_state = ST_TWO;
              w_skid_en    = 1'b1;
            end else begin
              w_next_state = ST_ONE;
            end
          end else if (w_out_fire) begin
            w_next_state = ST_EMPTY;
          end else begin
            w_next_state = ST_ONE;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the drain of the head can happen;
          // the parked beat then moves up, preserving FIFO order.
          if (w_out_fire) begin
            w_next_state    = ST_ONE;
            w_main_en       = 1'b1;
            w_main_sel_skid = 1'b1;
          end else begin
            w_next_state = ST_TWO;
          end
        end
        default: begin
          w_next_state = ST_EMPTY;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  assign w_main_d = w_main_sel_skid ? w_skid_q : in_data;

  flopenr #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .i_clr (flush),
    .i_en  (w_main_en),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  generate
    if (SKID != 0) begin : gen_skid
      logic r_in_ready;

      // Registered ready: low exactly while the stage will be full.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_next_state != ST_TWO);
        end
      end

      assign w_in_ready = r_in_ready;

      flopenr #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_skid (
        .clk   (clk),
        .reset (reset),
        .i_clr (flush),
        .i_en  (w_skid_en),
        .i_d   (in_data),
        .o_q   (w_skid_q)
      );
    end else begin : gen_no_skid
      // Single entry: accept whenever the held beat leaves this cycle.
      assign w_in_ready = ~w_out_valid | out_ready;
      assign w_skid_q   = RESET_VAL;
    end
  endgenerate

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_main_q;
  assign occupancy = state_to_occ(r_state);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
// Directed bench for pipe_stage_reg: a SKID=1 instance with a non-zero reset
// value, plus a SKID=0 instance driven with random handshakes against a
// sequence scoreboard.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int         W  = 9;
  localparam logic [8:0] RV = 9'h15A;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_data;
  logic [1:0] occupancy;

  logic       flush_0;
  logic       in_valid_0;
  logic       in_ready_0;
  logic [8:0] in_data_0;
  logic       out_valid_0;
  logic       out_ready_0;
  logic [8:0] out_data_0;
  logic [1:0] occupancy_0;

  int checks;
  int errors;

  pipe_stage_reg #(.WIDTH(W), .RESET_VAL(RV), .SKID(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  pipe_stage_reg #(.WIDTH(W), .RESET_VAL(9'h000), .SKID(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush_0),
    .in_valid  (in_valid_0),
    .in_ready  (in_ready_0),
    .in_data   (in_data_0),
    .out_valid (out_valid_0),
    .out_ready (out_ready_0),
    .out_data  (out_data_0),
    .occupancy (occupancy_0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 9'h123; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++;
      if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
      checks++;
      if (out_data !== RV) begin errors++; $display("FAIL reset_out_data: got %h expected %h", out_data, RV); end
    end
    reset = 1'b0; in_valid = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_streaming();
    logic [8:0] v;
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      v = i[8:0];
      in_valid = 1'b1; in_data = v;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== v) begin
        errors++; $display("FAIL stream_beat: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, v);
      end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready: got %b expected 1", in_ready); end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++; $display("FAIL stream_drain: got valid=%b occ=%0d expected valid=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 9'h0AA;
    step();
    checks++;
    if (occupancy !== 2'd1 || out_data !== 9'h0AA) begin
      errors++; $display("FAIL skid_first: got occ=%0d data=%h expected occ=1 data=0aa", occupancy, out_data);
    end
    in_data = 9'h0BB;
    step();
    checks++;
    if (occupancy !== 2'd2) begin errors++; $display("FAIL skid_occ2: got %0d expected 2", occupancy); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_in_ready: got %b expected 0", in_ready); end
    checks++;
    if (out_data !== 9'h0AA) begin errors++; $display("FAIL skid_head: got %h expected 0aa", out_data); end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 9'h0AA) begin
      errors++; $display("FAIL skid_stall_hold: got valid=%b data=%h expected valid=1 data=0aa", out_valid, out_data);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 9'h0BB || occupancy !== 2'd1) begin
      errors++; $display("FAIL skid_second: got valid=%b data=%h occ=%0d expected valid=1 data=0bb occ=1", out_valid, out_data, occupancy);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_back: got %b expected 1", in_ready); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 9'h011;
    step();
    // Flush in ONE while a beat is being accepted: both disappear.
    in_data = 9'h1FF; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== RV) begin
      errors++; $display("FAIL flush_one: got valid=%b occ=%0d data=%h expected valid=0 occ=0 data=%h", out_valid, occupancy, out_data, RV);
    end
    in_valid = 1'b1; in_data = 9'h022;
    step();
    in_data = 9'h033;
    step();
    checks++;
    if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_fill: got %0d expected 2", occupancy); end
    in_data = 9'h1FF; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== RV) begin
      errors++; $display("FAIL flush_two: got valid=%b occ=%0d data=%h expected valid=0 occ=0 data=%h", out_valid, occupancy, out_data, RV);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak: got valid=%b data=%h expected valid=0", out_valid, out_data); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 9'h044;
    step();
    in_data = 9'h055;
    step();
    checks++;
    if (occupancy !== 2'd2) begin errors++; $display("FAIL rmid_fill: got %0d expected 2", occupancy); end
    reset = 1'b1; in_valid = 1'b0;
    step();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== RV) begin
      errors++; $display("FAIL rmid_empty: got valid=%b occ=%0d data=%h expected valid=0 occ=0 data=%h", out_valid, occupancy, out_data, RV);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready); end
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 9'h066;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 9'h066) begin
      errors++; $display("FAIL rmid_restart1: got valid=%b data=%h expected valid=1 data=066", out_valid, out_data);
    end
    in_data = 9'h077;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 9'h077) begin
      errors++; $display("FAIL rmid_restart2: got valid=%b data=%h expected valid=1 data=077", out_valid, out_data);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_skid0_random();
    int  tx;
    int  rx;
    logic exp_valid;
    logic exp_ready;
    tx = 0; rx = 0;
    for (int c = 0; c < 200; c++) begin
      in_valid_0  = ($urandom_range(3, 0) != 0);
      out_ready_0 = ($urandom_range(1, 0) == 1);
      in_data_0   = tx[8:0];
      exp_valid   = (tx != rx);
      exp_ready   = !exp_valid || out_ready_0;
      #1;
      checks++;
      if (in_ready_0 !== exp_ready) begin
        errors++; $display("FAIL s0_in_ready cyc %0d: got %b expected %b", c, in_ready_0, exp_ready);
      end
      checks++;
      if (out_valid_0 !== exp_valid) begin
        errors++; $display("FAIL s0_out_valid cyc %0d: got %b expected %b", c, out_valid_0, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (out_data_0 !== rx[8:0]) begin
          errors++; $display("FAIL s0_order cyc %0d: got %h expected %h", c, out_data_0, rx[8:0]);
        end
      end
      if (exp_valid && out_ready_0) rx++;
      if (in_valid_0 && exp_ready) tx++;
      step();
    end
    in_valid_0 = 1'b0; out_ready_0 = 1'b1;
    step();
    checks++;
    if (out_valid_0 !== 1'b0 || occupancy_0 !== 2'd0) begin
      errors++; $display("FAIL s0_drain: got valid=%b occ=%0d expected valid=0 occ=0", out_valid_0, occupancy_0);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    flush_0 = 1'b0; in_valid_0 = 1'b0; in_data_0 = 9'h000; out_ready_0 = 1'b0;
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_reset_mid();
    test_skid0_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
